nw_job_scheduler: RTL and testbench

Front-end controller for the Needleman-Wunsch alignment grid. It accepts alignment jobs from NREQ requesters over valid/ready handshakes and picks one at a time with a round-robin arbiter. It loads the winning string pair into the grid, holds the grid in clear, releases it, waits for completion and returns the score to the owning requester. It sits between the host/DMA request ports and the single shared grid instance.

---
 rtl/nw_pkg.sv | 28 ++
 rtl/nw_rr_arbiter.sv | 37 +++
 rtl/nw_job_scheduler.sv | 154 +++++++++++++++
 tb/tb_nw_job_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared types and default sizes for the Needleman-Wunsch front end
//
// Contents:
//   NW_LENGTH / NW_CWIDTH / NW_SWIDTH  default string length, char width, score width
//   nw_state_t                         scheduler FSM states
//   nw_job_t                           one alignment job (string pair + requester id)
package nw_pkg;

    localparam int NW_LENGTH   = 10;
    localparam int NW_CWIDTH   = 2;
    localparam int NW_SWIDTH   = 16;
    localparam int NW_MAX_NREQ = 8;
    localparam int NW_IDWIDTH  = $clog2(NW_MAX_NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } nw_state_t;

    typedef struct packed {
        logic [NW_LENGTH*NW_CWIDTH-1:0] s1;
        logic [NW_LENGTH*NW_CWIDTH-1:0] s2;
        logic [NW_IDWIDTH-1:0]          id;
    } nw_job_t;

endpackage

// File: rtl/nw_rr_arbiter.sv
// rtl/nw_rr_arbiter.sv - combinational round-robin picker
//
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IDW   highest-priority index for this pick
//   grant  out NREQ  one-hot grant (zero when no request)
//   index  out IDW   encoded index of the granted bit (0 when no request)
module nw_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index
);

    int   k;
    logic found;

    // Scan NREQ positions starting at ptr, wrapping; the first set bit wins.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                index    = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/nw_job_scheduler.sv
// rtl/nw_job_scheduler.sv - round-robin job scheduler in front of the shared NW grid
//
// Optional feature macro: NW_SCHED_WDOG_EN (RUN watchdog, aborts with resp_err=1)
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   req_valid/req_ready         per-requester job handshake (ready one-hot or zero)
//   req_s1/req_s2               per-requester string pair, requester i at slice i
//   grid_s1/grid_s2/grid_clr    latched strings and active-high clear to the grid
//   grid_done/grid_score        grid completion and signed score
//   resp_valid/resp_ready       result handshake
//   resp_id/resp_score/resp_err result owner, score, watchdog abort flag
//   busy                        scheduler not idle
module nw_job_scheduler
    import nw_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int LENGTH     = NW_LENGTH,
    parameter int CWIDTH     = NW_CWIDTH,
    parameter int SWIDTH     = NW_SWIDTH,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 4*LENGTH*LENGTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]   req_s1,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]   req_s2,
    output logic [LENGTH*CWIDTH-1:0]        grid_s1,
    output logic [LENGTH*CWIDTH-1:0]        grid_s2,
    output logic                            grid_clr,
    input  logic                            grid_done,
    input  logic [SWIDTH-1:0]               grid_score,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [$clog2(NREQ)-1:0]         resp_id,
    output logic [SWIDTH-1:0]               resp_score,
    output logic                            resp_err,
    output logic                            busy
);

    localparam int IDW  = $clog2(NREQ);
    localparam int SW   = LENGTH*CWIDTH;
    localparam int CNTW = $clog2(CLR_CYCLES+1);

    nw_state_t        state, next_state;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_idx;
    logic [CNTW-1:0]  clr_cnt;
    logic             clr_done;
    logic             wd_expire;

    nw_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (win_idx)
    );

    assign clr_done = (clr_cnt >= CNTW'(CLR_CYCLES-1));

    always_comb begin
        next_state = state;
        req_ready  = '0;
        grid_clr   = 1'b1;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
                if (|req_valid) next_state = CLEAR;
            end
            CLEAR: begin
                // A grid that still reports done has not really cleared; wait it out.
                if (clr_done && !grid_done) next_state = RUN;
            end
            RUN: begin
                grid_clr = 1'b0;
                if (grid_done || wd_expire) next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            clr_cnt    <= '0;
            grid_s1    <= '0;
            grid_s2    <= '0;
            resp_id    <= '0;
            resp_score <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grid_s1 <= req_s1[int'(win_idx)*SW +: SW];
                        grid_s2 <= req_s2[int'(win_idx)*SW +: SW];
                        resp_id <= win_idx;
                        rr_ptr  <= (int'(win_idx) == NREQ-1) ? '0 : win_idx + IDW'(1);
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (!clr_done) clr_cnt <= clr_cnt + CNTW'(1);
                end
                RUN: begin
                    if (grid_done) resp_score <= grid_score;
                    else if (wd_expire) resp_score <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef NW_SCHED_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT+1);

    logic [WDW-1:0] wd_cnt;
    logic           err_q;

    // Counter is zero on the first RUN cycle; expiry is on the TIMEOUT-th RUN cycle.
    assign wd_expire = (state == RUN) && (wd_cnt == WDW'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (!reset || state != RUN) wd_cnt <= '0;
        else if (!wd_expire)        wd_cnt <= wd_cnt + WDW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)                          err_q <= 1'b0;
        else if (state == RUN && grid_done)  err_q <= 1'b0;
        else if (wd_expire)                  err_q <= 1'b1;
    end

    assign resp_err = err_q;
`else
    assign wd_expire = 1'b0;
    assign resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_nw_job_scheduler.sv
// tb/tb_nw_job_scheduler.sv - directed self-checking bench for nw_job_scheduler
module tb_nw_job_scheduler;

    localparam int NREQ = 2;
    localparam int LEN  = 10;
    localparam int CW   = 2;
    localparam int SWD  = 16;
    localparam int SW   = LEN*CW;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*SW-1:0]    req_s1, req_s2;
    logic [SW-1:0]         grid_s1, grid_s2;
    logic                  grid_clr;
    logic                  grid_done;
    logic [SWD-1:0]        grid_score;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [0:0]            resp_id;
    logic [SWD-1:0]        resp_score;
    logic                  resp_err;
    logic                  busy;

    logic [SW-1:0] s1_r [NREQ];
    logic [SW-1:0] s2_r [NREQ];

    int n_checks = 0;
    int n_fails  = 0;

    assign req_s1 = {s1_r[1], s1_r[0]};
    assign req_s2 = {s2_r[1], s2_r[0]};

    always #5 clk = ~clk;

    nw_job_scheduler #(
        .NREQ       (NREQ),
        .LENGTH     (LEN),
        .CWIDTH     (CW),
        .SWIDTH     (SWD),
        .CLR_CYCLES (2),
        .TIMEOUT    (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_s1     (req_s1),
        .req_s2     (req_s2),
        .grid_s1    (grid_s1),
        .grid_s2    (grid_s2),
        .grid_clr   (grid_clr),
        .grid_done  (grid_done),
        .grid_score (grid_score),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_score (resp_score),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Never more than one req_ready bit at once.
    always @(negedge clk) begin
        if (reset === 1'b1) check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    end

    task automatic check_reset_values();
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_grid_clr",   32'(grid_clr),   32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id",    32'(resp_id),    32'd0);
        check("rst_resp_score", 32'(resp_score), 32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        check("rst_grid_s1",    32'(grid_s1),    32'd0);
        check("rst_grid_s2",    32'(grid_s2),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
    endtask

    // Waits (bounded) for a grant, checks it, then takes the grant edge.
    task automatic grant_job(input int id);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 8) begin
            tick();
            n++;
        end
        check("grant", 32'(req_ready), 32'(1 << id));
        tick();
        check("grid_s1", 32'(grid_s1), 32'(s1_r[id]));
        check("grid_s2", 32'(grid_s2), 32'(s2_r[id]));
        check("busy_clear", 32'(busy), 32'd1);
        check("ready_clear", 32'(req_ready), 32'd0);
    endtask

    // Cycles 1 and 2 hold grid_clr, cycle 3 releases it.
    task automatic clear_phase();
        check("clr_cyc1", 32'(grid_clr), 32'd1);
        tick();
        check("clr_cyc2", 32'(grid_clr), 32'd1);
        tick();
        check("clr_cyc3", 32'(grid_clr), 32'd0);
    endtask

    task automatic finish_job(input int id, input logic [SWD-1:0] score, input int hold);
        grid_done  = 1'b1;
        grid_score = score;
        tick();
        grid_done  = 1'b0;
        grid_score = 16'h0bad;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_id",    32'(resp_id),    32'(id));
            check("hold_score", 32'(resp_score), 32'(score));
            check("hold_ready", 32'(req_ready),  32'd0);
            tick();
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_id",    32'(resp_id),    32'(id));
        check("resp_score", 32'(resp_score), 32'(score));
        check("resp_err",   32'(resp_err),   32'd0);
        check("resp_clr",   32'(grid_clr),   32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("idle_busy", 32'(busy),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        grid_done  = 1'b0;
        grid_score = '0;
        resp_ready = 1'b0;
        s1_r[0] = '0; s1_r[1] = '0;
        s2_r[0] = '0; s2_r[1] = '0;
        tick();
        tick();
        check_reset_values();
        reset = 1'b1;

        // Single job from requester 0, all-zero strings, score 10.
        req_valid = 2'b01;
        grant_job(0);
        req_valid = '0;
        clear_phase();
        finish_job(0, 16'd10, 0);

        // Fresh pointer, both requesters always valid: 0,1,0,1.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        s1_r[0] = 20'h12345; s2_r[0] = 20'h0abcd;
        s1_r[1] = 20'hfedcb; s2_r[1] = 20'h55555;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            grant_job(k % 2);
            clear_phase();
            finish_job(k % 2, (k == 1) ? 16'hfffb : 16'(100 + k), 0);
        end

        // Response back-pressure for 20 cycles.
        grant_job(0);
        clear_phase();
        finish_job(0, 16'h0321, 20);
        check("next_grant_after_accept", 32'(req_ready), 32'b10);
        req_valid = 2'b01;

        // Reset mid-RUN discards the job and returns the pointer to 0.
        grant_job(0);
        req_valid = '0;
        clear_phase();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_values();
        grid_done = 1'b1;
        tick();
        grid_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("no_resp_after_reset", 32'(resp_valid), 32'd0);
            tick();
        end
        req_valid = 2'b11;
        #1;
        check("ptr_after_reset", 32'(req_ready), 32'b01);

        // grid_done stuck high through CLEAR.
        grant_job(0);
        req_valid = '0;
        grid_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stuck_clr",   32'(grid_clr),   32'd1);
            check("stuck_valid", 32'(resp_valid), 32'd0);
            tick();
        end
        grid_done = 1'b0;
        check("stuck_release_clr", 32'(grid_clr), 32'd1);
        tick();
        check("stuck_run_clr", 32'(grid_clr), 32'd0);
        finish_job(0, 16'd7, 0);

        // grid_done never rises.
        grid_score = 16'h1234;
        req_valid  = 2'b10;
        grant_job(1);
        req_valid = '0;
        clear_phase();
        grid_score = 16'h1234;
`ifdef NW_SCHED_WDOG_EN
        for (int i = 0; i < 49; i++) tick();
        check("wdog_not_yet", 32'(resp_valid), 32'd0);
        tick();
        check("wdog_valid", 32'(resp_valid), 32'd1);
        check("wdog_err",   32'(resp_err),   32'd1);
        check("wdog_score", 32'(resp_score), 32'd0);
        check("wdog_id",    32'(resp_id),    32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("wdog_drop", 32'(resp_valid), 32'd0);
`else
        for (int i = 0; i < 60; i++) tick();
        check("nowdog_valid", 32'(resp_valid), 32'd0);
        check("nowdog_busy",  32'(busy),       32'd1);
        check("nowdog_err",   32'(resp_err),   32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
